// File: rtl/ad9637_pkg.sv
// Shared types and command-word constants for the AD9637 configuration sequencer.
package ad9637_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_T,
    S_LOAD_H,
    S_GO,
    S_WAIT,
    S_CMPL,
    S_ERR
  } state_t;

  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 20;
  localparam int ADDR_LSB = 8;

  localparam logic [12:0] REG_TRANSFER = 13'h0FF;
  localparam logic [23:0] TRANSFER_CMD = 24'h00FF01;

  function automatic logic is_read(input logic [23:0] cmd);
    return cmd[RW_BIT];
  endfunction

endpackage

// File: rtl/ad9637_cfg_sequencer_if.sv
// Host single-command request/acknowledge bus into the configuration sequencer.
interface ad9637_cfg_sequencer_if;
  logic        host_req;
  logic [23:0] host_cmd;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_err;

  modport master (output host_req, output host_cmd,
                  input  host_ack, input  host_rdata, input host_err);
  modport slave  (input  host_req, input  host_cmd,
                  output host_ack, output host_rdata, output host_err);
endinterface

// File: rtl/ad9637_spi_handshake.sv
// begintogo pulse, done rising-edge detect and saturating timeout counter for one transfer.
module ad9637_spi_handshake #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic waiting,
  input  logic spi_done,
  output logic spi_go,
  output logic cmpl,
  output logic tmo
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_go <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      spi_go <= start;
      done_q <= spi_done;
      if (start)
        cnt <= '0;
      else if (waiting && cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  // A done level carried over from the previous transfer has done_q high and is ignored.
  assign cmpl = waiting && spi_done && !done_q;
  assign tmo  = waiting && !cmpl && (cnt == CNT_LAST);

endmodule

// File: rtl/ad9637_cfg_sequencer.sv
// Plays the power-up command table into the AD9637 SPI engine, then serves host commands.
module ad9637_cfg_sequencer
  import ad9637_pkg::*;
#(
  parameter int TBL_DEPTH   = 16,
  parameter int TBL_AW      = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int AUTO_INIT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_start,
  output logic                   init_busy,
  output logic                   init_done,
  output logic                   init_err,
  output logic [TBL_AW-1:0]      tbl_addr,
  input  logic [23:0]            tbl_data,
  ad9637_cfg_sequencer_if.slave  host,
  output logic [23:0]            spi_cmd,
  output logic                   spi_go,
  input  logic                   spi_done,
  input  logic [7:0]             spi_rdata
);
  localparam logic [TBL_AW-1:0] ADDR_LAST = TBL_AW'(TBL_DEPTH - 1);

  state_t            state, state_d;
  logic              pend, pend_d;
  logic              src_host, src_host_d;
  logic              busy_d, done_d, err_d;
  logic [TBL_AW-1:0] addr_d;
  logic [23:0]       cmd_d;
  logic              ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              herr_q, herr_d;
  logic              cmpl, tmo;

  ad9637_spi_handshake #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_hs (
    .clk      (clk),
    .rst      (rst),
    .start    (state == S_GO),
    .waiting  (state == S_WAIT),
    .spi_done (spi_done),
    .spi_go   (spi_go),
    .cmpl     (cmpl),
    .tmo      (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= (AUTO_INIT != 0);
      src_host  <= 1'b0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      tbl_addr  <= '0;
      spi_cmd   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      herr_q    <= 1'b0;
    end else begin
      state     <= state_d;
      pend      <= pend_d;
      src_host  <= src_host_d;
      init_busy <= busy_d;
      init_done <= done_d;
      init_err  <= err_d;
      tbl_addr  <= addr_d;
      spi_cmd   <= cmd_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      herr_q    <= herr_d;
    end
  end

  always_comb begin
    state_d    = state;
    pend_d     = pend;
    src_host_d = src_host;
    busy_d     = init_busy;
    done_d     = init_done;
    err_d      = init_err;
    addr_d     = tbl_addr;
    cmd_d      = spi_cmd;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    herr_d     = herr_q;
    case (state)
      S_IDLE: begin
        if (pend) begin
          state_d = S_FETCH;
          pend_d  = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
        end else if (host.host_req && !ack_q) begin
          // the ack cycle is skipped so a host still holding req is not served twice
          state_d = S_LOAD_H;
        end
      end
      S_FETCH:  state_d = S_LOAD_T;
      S_LOAD_T: begin
        cmd_d      = tbl_data;
        src_host_d = 1'b0;
        state_d    = S_GO;
      end
      S_LOAD_H: begin
        cmd_d      = host.host_cmd;
        src_host_d = 1'b1;
        state_d    = S_GO;
      end
      S_GO:     state_d = S_WAIT;
      S_WAIT: begin
        if (cmpl)     state_d = S_CMPL;
        else if (tmo) state_d = S_ERR;
      end
      S_CMPL: begin
        state_d = S_IDLE;
        if (src_host) begin
          ack_d   = 1'b1;
          rdata_d = spi_rdata;
          herr_d  = 1'b0;
        end else if (pend || init_start) begin
          // restart requested mid-run: IDLE reloads address 0
        end else if (tbl_addr == ADDR_LAST) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          addr_d  = tbl_addr + TBL_AW'(1);
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
        if (src_host) begin
          ack_d   = 1'b1;
          herr_d  = 1'b1;
          rdata_d = '0;
        end else begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (init_start) begin
      pend_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  assign host.host_ack   = ack_q;
  assign host.host_rdata = rdata_q;
  assign host.host_err   = herr_q;

endmodule

// File: tb/tb_ad9637_cfg_sequencer.sv
// Scoreboard bench: stimulus queues expected SPI words and host acks, a monitor pops and compares.
module tb_ad9637_cfg_sequencer;
  localparam int LAT = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_start;
  logic        init_busy, init_done, init_err;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic [23:0] spi_cmd;
  logic        spi_go;
  logic        spi_done;
  logic [7:0]  spi_rdata;

  ad9637_cfg_sequencer_if hif();

  ad9637_cfg_sequencer #(
    .TBL_DEPTH(3), .TBL_AW(2), .TIMEOUT_CYC(64), .AUTO_INIT(1)
  ) dut (
    .clk(clk), .rst(rst), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .host(hif),
    .spi_cmd(spi_cmd), .spi_go(spi_go), .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [4];
  initial begin
    rom[0] = 24'h000801; rom[1] = 24'h001400; rom[2] = 24'h00FF01; rom[3] = 24'h000000;
  end
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // engine model: latches on go, drops done when it starts, raises done LAT+ cycles later
  logic hang = 1'b0;
  logic e_pend, e_busy, e_rd;
  int   e_cnt;
  always @(posedge clk) begin
    if (rst) begin
      spi_done <= 1'b0; spi_rdata <= 8'h00; e_pend <= 1'b0; e_busy <= 1'b0; e_cnt <= 0; e_rd <= 1'b0;
    end else if (spi_go) begin
      e_rd <= spi_cmd[23]; e_pend <= 1'b1;
    end else if (e_pend) begin
      e_pend <= 1'b0; spi_done <= 1'b0; e_busy <= 1'b1; e_cnt <= 0;
    end else if (e_busy && !hang) begin
      if (e_cnt >= LAT) begin
        e_busy <= 1'b0; spi_done <= 1'b1; spi_rdata <= e_rd ? 8'h88 : 8'h00;
      end else e_cnt <= e_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int go_cnt = 0;
  int last_go_cyc = 0;
  logic [23:0] exp_go[$];
  logic [8:0]  exp_ack[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // monitor
  logic [23:0] cmd_prev = '0;
  logic        go_prev = 1'b0;
  always @(negedge clk) begin
    logic [23:0] e;
    logic [8:0]  a;
    if (!rst) begin
      if (spi_go) begin
        go_cnt++;
        last_go_cyc = cyc;
        check("go_width", {31'd0, go_prev}, 32'd0);
        if (exp_go.size() == 0) check("go_unexpected", {8'd0, spi_cmd}, 32'hFFFFFFFF);
        else begin
          e = exp_go.pop_front();
          check("spi_cmd", {8'd0, spi_cmd}, {8'd0, e});
          check("cmd_setup", {8'd0, cmd_prev}, {8'd0, e});
        end
      end
      if (hif.host_ack) begin
        if (exp_ack.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else begin
          a = exp_ack.pop_front();
          check("host_rdata_err", {23'd0, hif.host_rdata, hif.host_err}, {23'd0, a});
          if (!a[0]) check_rng("ack_latency", cyc - last_go_cyc, LAT, LAT + 20);
        end
      end
    end
    cmd_prev = spi_cmd;
    go_prev  = spi_go;
  end

  task automatic wait_go(input int n, input int budget, input string nm);
    int k = 0;
    while (go_cnt < n && k < budget) begin @(posedge clk); k++; end
    check(nm, {31'd0, go_cnt >= n}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (!init_done && k < budget) begin @(negedge clk); k++; end
    check(nm, {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_ack(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (!hif.host_ack && k < budget) begin @(negedge clk); k++; end
    check(nm, {31'd0, hif.host_ack}, 32'd1);
    hif.host_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 init_start = 1'b1;
    @(posedge clk); #1 init_start = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_flags"}, {28'd0, init_busy, init_done, init_err, spi_go}, 32'd0);
    check({nm, "_addr"}, {30'd0, tbl_addr}, 32'd0);
    check({nm, "_cmd"}, {8'd0, spi_cmd}, 32'd0);
    check({nm, "_host"}, {22'd0, hif.host_ack, hif.host_rdata, hif.host_err}, 32'd0);
  endtask

  initial begin
    int k, g;
    rst = 1'b1; init_start = 1'b0; hif.host_req = 1'b0; hif.host_cmd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    for (int i = 0; i < 3; i++) exp_go.push_back(rom[i]);
    @(posedge clk); #1 rst = 1'b0;

    // auto-init, with a host read raised during entry 1
    wait_go(2, 500, "init_go2");
    #1 hif.host_req = 1'b1; hif.host_cmd = 24'h800100;
    exp_go.push_back(24'h800100); exp_ack.push_back({8'h88, 1'b0});
    wait_done(1000, "init_done_1");
    check("init_err_1", {31'd0, init_err}, 32'd0);
    check("gos_at_done", go_cnt, 32'd3);
    check("busy_after_done", {31'd0, init_busy}, 32'd0);
    wait_ack(500, "host_read_ack");

    // host write with spi_done still high from the read
    repeat (3) @(posedge clk);
    #1 hif.host_req = 1'b1; hif.host_cmd = 24'h0014AA;
    exp_go.push_back(24'h0014AA); exp_ack.push_back({8'h00, 1'b0});
    wait_ack(500, "host_write_ack");

    // engine hangs: timeout aborts the table
    hang = 1'b1;
    exp_go.push_back(rom[0]);
    pulse_start();
    check("start_clears_done", {31'd0, init_done}, 32'd0);
    k = 0;
    @(negedge clk);
    while (!init_err && k < 300) begin @(negedge clk); k++; end
    check("init_err_set", {31'd0, init_err}, 32'd1);
    check_rng("tmo_latency", cyc - last_go_cyc, 63, 66);
    g = go_cnt;
    repeat (100) @(negedge clk);
    check("no_go_after_err", go_cnt, g);
    check("busy_after_err", {31'd0, init_busy}, 32'd0);

    // replay from address 0
    hang = 1'b0;
    for (int i = 0; i < 3; i++) exp_go.push_back(rom[i]);
    pulse_start();
    check("start_clears_err", {31'd0, init_err}, 32'd0);
    wait_done(1000, "init_done_replay");
    check("init_err_replay", {31'd0, init_err}, 32'd0);

    // reset mid-WAIT of a host write
    g = go_cnt;
    @(posedge clk); #1 hif.host_req = 1'b1; hif.host_cmd = 24'h001455;
    exp_go.push_back(24'h001455);
    wait_go(g + 1, 200, "host_go_before_rst");
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; hif.host_req = 1'b0;
    for (int i = 0; i < 3; i++) exp_go.push_back(rom[i]);
    @(posedge clk); #1 rst = 1'b0;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    check("auto_reinit_busy", {31'd0, init_busy}, 32'd1);
    wait_done(1000, "init_done_after_rst");

    repeat (20) @(posedge clk);
    check("go_queue_empty", exp_go.size(), 32'd0);
    check("ack_queue_empty", exp_ack.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish by cycle %0d, expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ad9637_cfg_sequencer.md
Name: ad9637_cfg_sequencer

Overview:
- Controller that sits in front of the AD9637 3-wire SPI engine and owns its begintogo/done handshake.
- Plays a power-up configuration table (24-bit SPI command words read from an external ROM) into the ADC.
- Afterwards, arbitrates single-command host requests (AXI-lite register block) onto the same engine and returns read data.
- Flags a timeout when the engine fails to report completion.

Parameters:
- TBL_DEPTH, 16, number of command words in the init table; words are played at addresses 0..TBL_DEPTH-1.
- TBL_AW, 4, table address width; must satisfy 2**TBL_AW >= TBL_DEPTH.
- TIMEOUT_CYC, 4096, clk cycles allowed from spi_go to the spi_done rising edge.
- AUTO_INIT, 1, 1 = start an init run on the first cycle after reset release.

Ports:
- clk  in  1  system clock; the SPI engine runs on the same clock.
- rst  in  1  synchronous, active-high reset; the top level drives the engine reset as rst_n = ~rst, so both reset together.
- init_start  in  1  one-cycle pulse; (re)runs the init table.
- init_busy  out  1  high while an init run is in progress.
- init_done  out  1  sticky; set when an init run completes without error, cleared by init_start.
- init_err  out  1  sticky; set on timeout, cleared by init_start.
- tbl_addr  out  TBL_AW  ROM address.
- tbl_data  in  24  ROM data; valid exactly 1 cycle after tbl_addr.
- host_req  in  1  level request; host_cmd is held stable until host_ack.
- host_cmd  in  24  {R/W#, W1:W0, A12:A0, D7:D0}; bit 23 = 1 means read.
- host_ack  out  1  one-cycle pulse when the host command finishes or times out.
- host_rdata  out  8  read data; valid with host_ack, holds until the next ack.
- host_err  out  1  valid with host_ack; 1 = timeout.
- spi_cmd  out  24  command word to the engine (Reg_Ctrl_In); held stable from issue until completion.
- spi_go  out  1  begintogo pulse to the engine.
- spi_done  in  1  engine done flag; level signal that clears when the next transfer starts.
- spi_rdata  in  8  engine Reg_Read_Out.

Behaviour:
- Reset values: init_busy=0, init_done=0, init_err=0, tbl_addr=0, host_ack=0, host_rdata=0, host_err=0, spi_cmd=0, spi_go=0; state=IDLE; pending-start flag = AUTO_INIT.
- spi_cmd is driven 1 cycle before spi_go and stays unchanged until completion.
- spi_go is high for exactly 1 cycle. The engine latches spi_cmd while idle and starts only after spi_go has returned low.
- Completion is the rising edge of spi_done, detected against a registered copy of spi_done (done_q). A level-high spi_done left over from a previous transfer never counts as completion.
- State machine:
  - IDLE: if the start flag is pending, go to FETCH with tbl_addr=0 and init_busy=1. Else if host_req, go to LOAD_H. Init always has priority over the host.
  - FETCH: ROM latency cycle, then go to LOAD_T.
  - LOAD_T / LOAD_H: spi_cmd <= tbl_data or host_cmd, then go to GO.
  - GO: spi_go=1, timeout counter cleared, then go to WAIT.
  - WAIT: on the done rising edge, go to CMPL. If the counter reaches TIMEOUT_CYC-1, go to ERR.
  - CMPL, table source: if tbl_addr == TBL_DEPTH-1, set init_done=1, init_busy=0 and go to IDLE. Else increment tbl_addr and go to FETCH.
  - CMPL, host source: host_ack=1, host_rdata=spi_rdata (for writes it carries the engine value, 0x00), host_err=0, then go to IDLE.
  - ERR: table source sets init_err=1, init_busy=0 and aborts the remaining entries. Host source sets host_ack=1, host_err=1, host_rdata=0. Both return to IDLE.
- init_start arriving in any non-IDLE state sets the pending flag; the run begins after the current transfer ends. An init_start pulse during an init run restarts from address 0 after the current word.
- init_start also clears init_done and init_err on the cycle it is seen.
- host_req dropped before host_ack is a protocol violation; the command already issued still completes and the ack is still pulsed.
- Minimum IDLE-to-IDLE for one command: 4 controller cycles plus the engine transfer time.
- Timeout counter is ceil(log2(TIMEOUT_CYC)) bits wide and saturates; it never wraps.
- rst in any state returns to IDLE with reset values. The engine is reset simultaneously, so no partial transfer survives.

Decomposition:
- Shared package ad9637_pkg:
  - state enum;
  - command field constants: RW_BIT=23, ADDR_MSB=20, ADDR_LSB=8;
  - register constants: REG_TRANSFER=13'h0FF, TRANSFER_CMD=24'h00FF01.
- One natural sub-module, ad9637_spi_handshake. It owns the spi_go pulse, done_q edge detect and timeout counter, and returns one-cycle cmpl/tmo strobes to the sequencer FSM.

Test Plan:
- Auto-init with AUTO_INIT=1, 3-entry table {000801, 001400, 00FF01} and an engine model (done 50 cycles after go) -> exactly 3 spi_go pulses; spi_cmd equals each word in order; init_done=1 after the third; init_err=0.
- Host read: host_cmd=0x800100 with the model returning 0x88 -> one spi_go; host_ack pulses once with host_rdata=0x88, host_err=0.
- Priority: host_req raised during init entry 1 -> host command issued only after init_done=1; the host's spi_go follows the last table spi_go.
- Timeout: model never raises done, TIMEOUT_CYC=64 -> init_err=1 at 64 cycles after spi_go; no further spi_go; init_start then replays from address 0 and clears init_err.
- Stale done: spi_done held high from the prior transfer, then a new host write -> no ack until done falls and rises again.
- Reset mid-WAIT: rst pulsed for 1 cycle -> all outputs return to reset values next cycle; a new init run begins when AUTO_INIT=1.
